// File: rtl/spu_fetch_issue_buffer.sv
// spu_fetch_issue_buffer
// Fetch and pair-buffer stage of the dual-issue SPU-lite pipeline. Holds the
// program counter, requests aligned 64-bit instruction pairs from the local
// store and queues them in a registered FIFO for decode. Handles branch
// redirect (including odd-word targets), flush and the stop instruction.
module spu_fetch_issue_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  output logic              inst_valid,
  output logic [31:0]       first_inst,
  output logic [31:0]       second_inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_V = (PTR_W+2)'(DEPTH);
  localparam logic [31:0] NOP_INST = 32'h4020_0000;

  localparam logic [0:0] ST_FETCH  = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]        state;
  logic              active;
  logic [ADDR_W-1:0] pc;
  logic              next_odd;
  logic              req_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              req_odd_q;

  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] mem_pc     [DEPTH];
  logic [31:0]       mem_first  [DEPTH];
  logic [31:0]       mem_second [DEPTH];

  logic [PTR_W+1:0]  fill;
  logic              redirect;
  logic              head_stop;
  logic              pop;
  logic              stop_pop;
  logic              push;
  logic              clear;
  logic [31:0]       head_first;
  logic [31:0]       head_second;

  // Request gating, queue handshakes and head-of-queue decoding.
  always_comb begin
    fill        = {1'b0, count} + {{(PTR_W+1){1'b0}}, req_q};
    redirect    = branch_taken | flush;
    head_first  = mem_first[rd_ptr];
    head_second = mem_second[rd_ptr];
    head_stop   = (head_first[31:21] == 11'd0) || (head_second[31:21] == 11'd0);
    inst_valid  = (count != '0) && (state == ST_FETCH);
    pop         = inst_valid && !stall;
    stop_pop    = pop && head_stop;
    clear       = redirect || stop_pop;
    imem_req    = active && (state == ST_FETCH) && (fill < DEPTH_V) && !clear;
    push        = req_q && !clear;
    imem_addr   = imem_req ? pc : '0;
    first_inst  = inst_valid ? head_first : '0;
    second_inst = inst_valid ? head_second : '0;
    inst_pc     = inst_valid ? mem_pc[rd_ptr] : '0;
    halted      = (state == ST_HALTED);
  end

  // Fetch control: state, program counter, odd-target tag and in-flight tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      active    <= 1'b0;
      pc        <= '0;
      next_odd  <= 1'b0;
      req_q     <= 1'b0;
      req_pc_q  <= '0;
      req_odd_q <= 1'b0;
    end else begin
      active    <= 1'b1;
      req_q     <= imem_req;
      req_pc_q  <= pc;
      req_odd_q <= next_odd;
      if (branch_taken) begin
        state    <= ST_FETCH;
        pc       <= {branch_target[ADDR_W-1:3], 3'b000};
        next_odd <= branch_target[2];
      end else begin
        if (flush || stop_pop) begin
          state <= ST_HALTED;
        end
        if (imem_req) begin
          pc       <= pc + ADDR_W'(8);
          next_odd <= 1'b0;
        end
      end
    end
  end

  // Queue pointers and occupancy; redirect, flush or stop empties the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (!push && pop) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // Queue storage; an odd-tagged pair carries a nop in its even slot.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr]     <= req_pc_q;
      mem_first[wr_ptr]  <= req_odd_q ? NOP_INST : imem_rdata[63:32];
      mem_second[wr_ptr] <= imem_rdata[31:0];
    end
  end

endmodule

// File: tb/tb_spu_fetch_issue_buffer.sv
// tb_spu_fetch_issue_buffer
// Directed testbench for the fetch/pair-buffer stage. The local store is a
// small model whose word at byte address a is 32'hC000_0000 + a, except an
// optional stop word (all zero) at a chosen address.
module tb_spu_fetch_issue_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 15;

  logic              clock;
  logic              reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [63:0]       imem_rdata;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic              inst_valid;
  logic [31:0]       first_inst;
  logic [31:0]       second_inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              halted;

  int vectors = 0;
  int miscompares = 0;

  logic              stop_en = 1'b0;
  logic [ADDR_W-1:0] stop_addr = '0;

  spu_fetch_issue_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .flush(flush), .inst_valid(inst_valid), .first_inst(first_inst),
    .second_inst(second_inst), .inst_pc(inst_pc), .halted(halted)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    if (stop_en && (a == stop_addr)) return 32'h0000_0000;
    return 32'hC000_0000 + {17'd0, a};
  endfunction

  // Local store model: pair data valid the cycle after a request.
  always @(posedge clock or negedge reset) begin
    if (!reset) imem_rdata <= '0;
    else if (imem_req) imem_rdata <= {word_at(imem_addr), word_at(imem_addr + 15'd4)};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [ADDR_W-1:0] t, input logic f);
    stall = s;
    branch_taken = b;
    branch_target = t;
    flush = f;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Hold reset through one edge, release it; the next nextCycle lands in cycle 0.
  task automatic applyReset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " valid"}, 64'(inst_valid), 64'd0);
    checkOutput({tag, " first"}, 64'(first_inst), 64'd0);
    checkOutput({tag, " second"}, 64'(second_inst), 64'd0);
    checkOutput({tag, " pc"}, 64'(inst_pc), 64'd0);
    checkOutput({tag, " req"}, 64'(imem_req), 64'd0);
    checkOutput({tag, " addr"}, 64'(imem_addr), 64'd0);
    checkOutput({tag, " halted"}, 64'(halted), 64'd0);
  endtask

  task automatic checkPair(input string tag, input logic [ADDR_W-1:0] pc,
                           input logic [31:0] f, input logic [31:0] s);
    checkOutput({tag, " valid"}, 64'(inst_valid), 64'd1);
    checkOutput({tag, " pc"}, 64'(inst_pc), 64'(pc));
    checkOutput({tag, " first"}, 64'(first_inst), 64'(f));
    checkOutput({tag, " second"}, 64'(second_inst), 64'(s));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    flush = 1'b0;
    #2;
    checkIdleOutputs("reset");

    // Streaming with stall low.
    applyReset();
    nextCycle(); applyStimulus(0, 0, '0, 0);
    checkOutput("s c0 req", 64'(imem_req), 64'd1);
    checkOutput("s c0 addr", 64'(imem_addr), 64'h0);
    checkOutput("s c0 valid", 64'(inst_valid), 64'd0);
    nextCycle();
    checkOutput("s c1 addr", 64'(imem_addr), 64'h8);
    checkOutput("s c1 valid", 64'(inst_valid), 64'd0);
    nextCycle();
    checkOutput("s c2 addr", 64'(imem_addr), 64'h10);
    checkPair("s c2", 15'h0, 32'hC000_0000, 32'hC000_0004);
    nextCycle();
    checkPair("s c3", 15'h8, 32'hC000_0008, 32'hC000_000C);
    nextCycle();
    checkPair("s c4", 15'h10, 32'hC000_0010, 32'hC000_0014);
    checkOutput("s c4 halted", 64'(halted), 64'd0);

    // Stall from cycle 0: exactly DEPTH requests, then drain in order.
    stall = 1'b1;
    applyReset();
    nextCycle(); checkOutput("f c0 addr", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h00}));
    nextCycle(); checkOutput("f c1 addr", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h08}));
    nextCycle(); checkOutput("f c2 addr", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h10}));
    nextCycle(); checkOutput("f c3 addr", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h18}));
    nextCycle(); checkOutput("f c4 req", 64'(imem_req), 64'd0);
    nextCycle(); checkOutput("f c5 req", 64'(imem_req), 64'd0);
    checkPair("f c5 held", 15'h0, 32'hC000_0000, 32'hC000_0004);
    nextCycle(); applyStimulus(0, 0, '0, 0);
    checkOutput("f c6 req", 64'(imem_req), 64'd0);
    checkPair("f c6", 15'h0, 32'hC000_0000, 32'hC000_0004);
    nextCycle();
    checkPair("f c7", 15'h8, 32'hC000_0008, 32'hC000_000C);
    checkOutput("f c7 resume", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h20}));
    nextCycle(); checkPair("f c8", 15'h10, 32'hC000_0010, 32'hC000_0014);
    nextCycle(); checkPair("f c9", 15'h18, 32'hC000_0018, 32'hC000_001C);
    nextCycle(); checkPair("f c10", 15'h20, 32'hC000_0020, 32'hC000_0024);

    // Branch to an odd-word target with 2 queued and 1 in flight.
    stall = 1'b1;
    applyReset();
    repeat (4) nextCycle();
    applyStimulus(1, 1, 15'h0104, 0);
    checkPair("b c3 queued", 15'h0, 32'hC000_0000, 32'hC000_0004);
    checkOutput("b c3 req", 64'(imem_req), 64'd0);
    nextCycle(); applyStimulus(0, 0, '0, 0);
    checkOutput("b c4 req", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h0100}));
    checkOutput("b c4 valid", 64'(inst_valid), 64'd0);
    nextCycle();
    checkOutput("b c5 valid", 64'(inst_valid), 64'd0);
    checkOutput("b c5 addr", 64'(imem_addr), 64'h0108);
    nextCycle(); checkPair("b c6 odd", 15'h0100, 32'h4020_0000, 32'hC000_0104);
    nextCycle(); checkPair("b c7", 15'h0108, 32'hC000_0108, 32'hC000_010C);

    // Stop in the even slot of the pair at 0x10.
    stop_en = 1'b1;
    stop_addr = 15'h0010;
    stall = 1'b0;
    applyReset();
    repeat (5) nextCycle();
    checkPair("t c4 stop", 15'h10, 32'h0000_0000, 32'hC000_0014);
    nextCycle();
    checkOutput("t c5 halted", 64'(halted), 64'd1);
    checkOutput("t c5 valid", 64'(inst_valid), 64'd0);
    checkOutput("t c5 req", 64'(imem_req), 64'd0);
    nextCycle();
    checkOutput("t c6 req", 64'(imem_req), 64'd0);
    checkOutput("t c6 halted", 64'(halted), 64'd1);
    stop_en = 1'b0;
    nextCycle(); applyStimulus(0, 1, 15'h0000, 0);
    nextCycle(); applyStimulus(0, 0, '0, 0);
    checkOutput("t c8 req", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h0}));
    checkOutput("t c8 halted", 64'(halted), 64'd0);
    nextCycle(); nextCycle();
    checkPair("t c10", 15'h0, 32'hC000_0000, 32'hC000_0004);

    // Flush alone halts; flush with branch resumes at the target.
    applyReset();
    repeat (4) nextCycle();
    applyStimulus(0, 0, '0, 1);
    checkPair("l c3", 15'h8, 32'hC000_0008, 32'hC000_000C);
    nextCycle(); applyStimulus(0, 0, '0, 0);
    checkOutput("l c4 halted", 64'(halted), 64'd1);
    checkOutput("l c4 valid", 64'(inst_valid), 64'd0);
    checkOutput("l c4 req", 64'(imem_req), 64'd0);
    nextCycle();
    checkOutput("l c5 valid", 64'(inst_valid), 64'd0);
    nextCycle(); applyStimulus(0, 1, 15'h0040, 1);
    checkOutput("l c6 halted", 64'(halted), 64'd1);
    nextCycle(); applyStimulus(0, 0, '0, 0);
    checkOutput("l c7 halted", 64'(halted), 64'd0);
    checkOutput("l c7 req", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h0040}));
    nextCycle(); nextCycle();
    checkPair("l c9", 15'h0040, 32'hC000_0040, 32'hC000_0044);

    // Asynchronous reset mid-stream with a full queue.
    stall = 1'b1;
    applyReset();
    repeat (7) nextCycle();
    checkPair("r full", 15'h0, 32'hC000_0000, 32'hC000_0004);
    checkOutput("r full req", 64'(imem_req), 64'd0);
    reset = 1'b0;
    #1;
    checkIdleOutputs("r async");
    stall = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    nextCycle();
    checkOutput("r c0 req", 64'({imem_req, imem_addr}), 64'({1'b1, 15'h0}));
    nextCycle(); nextCycle();
    checkPair("r c2", 15'h0, 32'hC000_0000, 32'hC000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spu_fetch_issue_buffer.md
# spu_fetch_issue_buffer

Instruction fetch and pair-buffer stage of the dual-issue SPU-lite pipeline. It holds the program counter and fetches aligned 64-bit instruction pairs from the instruction local store. Pairs are queued in a small FIFO and presented to decode as `first_inst` / `second_inst`. The block handles branch redirect, flush, odd-word branch targets and `stop`.

## Interface
Parameters:
- `DEPTH`, 4: pair-queue entries (power of two, ≥2)
- `ADDR_W`, 15: byte-address width (32 KB local store)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  read request to instruction LS
- `imem_addr`  out  ADDR_W  pair-aligned byte address; bits [ADDR_W-3:ADDR_W-1] always 0
- `imem_rdata`  in  64  pair data, valid exactly 1 cycle after `imem_req`; [0:31] = word at addr, [32:63] = word at addr+4
- `stall`  in  1  decode cannot accept this cycle
- `branch_taken`  in  1  redirect to `branch_target`
- `branch_target`  in  ADDR_W  word-aligned byte address
- `flush`  in  1  discard all queued/in-flight pairs and halt fetch
- `inst_valid`  out  1  head pair presented
- `first_inst`  out  32  even-slot instruction
- `second_inst`  out  32  odd-slot instruction
- `inst_pc`  out  ADDR_W  pair-aligned address of head pair
- `halted`  out  1  fetch stopped (`stop` consumed or `flush`)

## Operation
- States: FETCH, HALTED. Reset enters FETCH with PC=0.
- FETCH behaviour:
  - Assert `imem_req` with `imem_addr`=PC when `occupancy + inflight < DEPTH` and no redirect/flush this cycle.
  - On request, PC += 8, wrapping modulo 2^ADDR_W.
- Response handling: one cycle after a request, `imem_rdata` is pushed with its pc and an `odd` tag, unless squashed.
- Squash: any `branch_taken` or `flush` in the request cycle or the response cycle discards that response.
- Pop: the head pops when `inst_valid && !stall`.
- `branch_taken` (any state):
  - Clear the queue and squash in-flight data.
  - PC ← `branch_target` with bits [ADDR_W-3:ADDR_W-1] cleared.
  - Tag the first fetched pair `odd` = `branch_target` bit [ADDR_W-3].
  - Enter FETCH.
- `odd` pair delivery: `first_inst` = 32'h4020_0000 (nop); `second_inst` = rdata[32:63].
- `flush` without `branch_taken`: clear the queue, squash in-flight data, enter HALTED. PC is unchanged.
- `flush` and `branch_taken` in the same cycle: `branch_taken` wins and the state is FETCH.
- `stop` (bits [0:10]==0) in either delivered slot when the pair pops:
  - Enter HALTED and clear the rest of the queue.
  - If `stop` is in the even slot, the odd slot is still delivered as part of the same pair; decode discards it.
- HALTED: no requests, `inst_valid`=0, `halted`=1. Exit only via `branch_taken`.
- Outputs are 0 when `inst_valid`=0.

## Timing
- Reset (async assert) outputs:
  - `inst_valid`=0, `first_inst`=0, `second_inst`=0, `inst_pc`=0
  - `imem_req`=0, `imem_addr`=0, `halted`=0
  - queue empty, inflight=0, PC=0
- First request: first rising edge after `reset` deasserts, counted as cycle 0 with `imem_req`=1, addr 0.
- Fetch latency: request in cycle n → data in cycle n+1 → `inst_valid` in cycle n+2. The FIFO is registered, not fall-through.
- Throughput: with `stall` low, one pair per cycle sustained.
- Full: with `stall` held high, exactly DEPTH pairs are accepted. `imem_req` drops once `occupancy + inflight` = DEPTH. It resumes the cycle after a pop.
- Simultaneous pop and push: occupancy is unchanged.
- `branch_taken` with `stall` high: the head is discarded, not popped.
- Redirect:
  - `branch_taken` in cycle b → `imem_req` to the target in cycle b+1 → `inst_valid` in cycle b+3.
  - `inst_valid`=0 in cycles b+1 and b+2.
- Mid-operation reset clears all state immediately, regardless of `stall` or in-flight data.

## Test plan
- Reset release, `stall`=0, LS pairs at 0/8/16 → `imem_addr` 0,8,16 on cycles 0,1,2. `inst_valid` from cycle 2 with `inst_pc` 0,8,16 and matching slots.
- `stall`=1 from cycle 0 with DEPTH=4 → exactly 4 requests (addr 0..24), `imem_req`=0 afterward. Release `stall` → pairs 0..24 in order, none lost or duplicated.
- `branch_taken` with target 0x0104 while 2 pairs are queued and 1 in flight → queue emptied, next req addr 0x0100. Delivered pair has `first_inst`=32'h4020_0000, `second_inst`=word at 0x0104, `inst_pc`=0x0100; next pair pc 0x0108.
- Pair at 0x0010 with even slot 32'h0000_0000 (stop) → pair delivered, then `halted`=1, `inst_valid`=0, no further `imem_req`. A `branch_taken` to 0 resumes fetch at 0.
- `flush` alone while fetching → `halted`=1 next cycle, queued pairs never appear. `flush` + `branch_taken` together → FETCH continues at the target.
- Assert `reset`=0 mid-stream with a full queue → all outputs 0 asynchronously. After release, refetch from addr 0.
